// File: rtl/uram_arb_pkg.sv
// Shared types and helpers for the polyvec URAM arbiter.
//   gnt_e     : which client won the most recent read/write conflict
//   uram_lat  : URAM read latency from its output pipeline depth
package uram_arb_pkg;

   typedef enum logic {
      GNT_WRITE = 1'b0,
      GNT_READ  = 1'b1
   } gnt_e;

   // The URAM has one array register stage plus COMMON_URAM_DELAY output
   // register stages, so data comes back delay+1 cycles after the address.
   function automatic int uram_lat(input int delay);
      return delay + 1;
   endfunction

endpackage

// File: rtl/polyvec_rsp_fifo.sv
// Synchronous response FIFO that holds URAM read data until the read consumer
// takes it. It provides first-word fall-through: the head entry is always
// visible on o_dout.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (discards contents)
//   i_push/i_din: write one entry (must not be full)
//   i_pop       : remove the head entry (ignored when empty)
//   o_dout      : head entry
//   o_empty     : no entries stored
//   o_count     : number of stored entries
module polyvec_rsp_fifo #(
   parameter int WIDTH = 140,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_din,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_dout,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;
   logic             w_doPop;
   logic             w_full;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_doPop = i_pop && (r_count != '0);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rdPtr];

   // Storage carries no reset: an entry is only visible once the count
   // says it has been written.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_mem[r_wrPtr] <= i_din;
      end
   end

   // Pointers wrap explicitly so that non-power-of-two depths still work.
   // A simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH-1)) ? '0 : r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH-1)) ? '0 : r_rdPtr + 1'b1;
         end
         if (i_push && !w_doPop) begin
            r_count <= r_count + 1'b1;
         end else if (!i_push && w_doPop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

   // The upstream credit scheme must never let a push land on a full FIFO.
   assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/uram_polyvec_arb.sv
// Shares one single-port polyvec URAM between a write client and a read
// client. One request is granted per cycle with round-robin priority on
// conflicts. Read data returning from the URAM is captured in a
// credit-protected response FIFO, so the consumer can stall without
// stalling the URAM pipeline.
// Optional feature: define URAM_ARB_STAT_EN to build a saturating 32-bit
// counter of conflict cycles on stat_conflict; otherwise it is tied to 0.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   wr_valid/wr_ready/wr_addr/wr_data : write client handshake
//   rd_valid/rd_ready/rd_addr  : read request handshake
//   rsp_valid/rsp_ready/rsp_data : read response stream (FIFO head)
//   mem_en/mem_we/mem_addr/mem_din/mem_dout : URAM interface
//   busy                       : a read is in flight or the FIFO holds data
//   stat_conflict              : conflict-cycle counter
module uram_polyvec_arb
   import uram_arb_pkg::*;
#(
   parameter int COE_WIDTH         = 35,
   parameter int ADDR_WIDTH        = 12,
   parameter int NUM_POLY          = 4,
   parameter int COMMON_URAM_DELAY = 1,
   parameter int RSP_DEPTH         = 4
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    wr_valid,
   output logic                                    wr_ready,
   input  logic [ADDR_WIDTH-1:0]                   wr_addr,
   input  logic [NUM_POLY-1:0][COE_WIDTH-1:0]      wr_data,
   input  logic                                    rd_valid,
   output logic                                    rd_ready,
   input  logic [ADDR_WIDTH-1:0]                   rd_addr,
   output logic                                    rsp_valid,
   input  logic                                    rsp_ready,
   output logic [NUM_POLY-1:0][COE_WIDTH-1:0]      rsp_data,
   output logic                                    mem_en,
   output logic                                    mem_we,
   output logic [ADDR_WIDTH-1:0]                   mem_addr,
   output logic [NUM_POLY-1:0][COE_WIDTH-1:0]      mem_din,
   input  logic [NUM_POLY-1:0][COE_WIDTH-1:0]      mem_dout,
   output logic                                    busy,
   output logic [31:0]                             stat_conflict
);

   localparam int LAT   = uram_lat(COMMON_URAM_DELAY);
   localparam int DW    = NUM_POLY * COE_WIDTH;
   localparam int CNT_W = $clog2(RSP_DEPTH+1);

   gnt_e             r_lastGrant;
   gnt_e             w_lastGrantNext;
   logic [LAT-1:0]   r_validPipe;
   logic [CNT_W-1:0] w_fifoCount;
   logic             w_fifoEmpty;
   logic [DW-1:0]    w_fifoDout;
   int               w_inflight;
   logic             w_credit;
   logic             w_wrElig;
   logic             w_rdElig;
   logic             w_wrGrant;
   logic             w_rdGrant;

   // Count reads still travelling through the URAM pipeline. Together with
   // the FIFO occupancy this is every read that still needs a FIFO slot.
   always_comb begin
      w_inflight = 0;
      for (int i = 0; i < LAT; i++) begin
         w_inflight = w_inflight + int'(r_validPipe[i]);
      end
   end

   // Requests are ignored while reset is asserted so that every output
   // stays at zero during reset.
   assign w_credit = (int'(w_fifoCount) + w_inflight) < RSP_DEPTH;
   assign w_wrElig = wr_valid && rst_n;
   assign w_rdElig = rd_valid && w_credit && rst_n;

   // Arbitration: a lone eligible client always wins. On a conflict the
   // client that did not win the previous conflict goes first, and only
   // conflicts move the round-robin pointer.
   always_comb begin
      w_wrGrant       = 1'b0;
      w_rdGrant       = 1'b0;
      w_lastGrantNext = r_lastGrant;
      if (w_wrElig && w_rdElig) begin
         if (r_lastGrant == GNT_READ) begin
            w_wrGrant       = 1'b1;
            w_lastGrantNext = GNT_WRITE;
         end else begin
            w_rdGrant       = 1'b1;
            w_lastGrantNext = GNT_READ;
         end
      end else begin
         w_wrGrant = w_wrElig;
         w_rdGrant = w_rdElig;
      end
   end

   // Round-robin pointer. It starts at READ so the first conflict favours
   // the writer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lastGrant <= GNT_READ;
      end else begin
         r_lastGrant <= w_lastGrantNext;
      end
   end

   // One bit per cycle of URAM latency. The oldest bit marks the cycle in
   // which mem_dout carries the data for an earlier read. Reset drops any
   // reads that are in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_validPipe <= '0;
      end else begin
         r_validPipe[0] <= w_rdGrant;
         for (int i = 1; i < LAT; i++) begin
            r_validPipe[i] <= r_validPipe[i-1];
         end
      end
   end

   assign wr_ready = w_wrGrant;
   assign rd_ready = w_rdGrant;
   assign mem_en   = w_wrGrant || w_rdGrant;
   assign mem_we   = w_wrGrant;
   assign mem_addr = w_wrGrant ? wr_addr : (w_rdGrant ? rd_addr : '0);
   assign mem_din  = w_wrGrant ? wr_data : '0;

   polyvec_rsp_fifo #(
      .WIDTH (DW),
      .DEPTH (RSP_DEPTH)
   ) u_rspFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (r_validPipe[LAT-1]),
      .i_din   (mem_dout),
      .i_pop   (rsp_valid && rsp_ready),
      .o_dout  (w_fifoDout),
      .o_empty (w_fifoEmpty),
      .o_count (w_fifoCount)
   );

   assign rsp_valid = !w_fifoEmpty;
   assign rsp_data  = w_fifoDout;
   assign busy      = (|r_validPipe) || (w_fifoCount != '0);

`ifdef URAM_ARB_STAT_EN
   logic [31:0] r_statConflict;

   // Counts cycles in which both clients were eligible. The counter
   // saturates instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_statConflict <= '0;
      end else if (w_wrElig && w_rdElig && (r_statConflict != '1)) begin
         r_statConflict <= r_statConflict + 32'd1;
      end
   end

   assign stat_conflict = r_statConflict;
`else
   assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_uram_polyvec_arb.sv
// Self-checking bench for uram_polyvec_arb, with a behavioural URAM model.
// The reference model treats every granted read as an outstanding response
// that becomes visible three cycles after its grant and leaves on a
// consumer handshake.
module tb_uram_polyvec_arb;

   localparam int CW    = 35;
   localparam int AW    = 12;
   localparam int NP    = 4;
   localparam int DW    = NP * CW;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_valid, wr_ready, rd_valid, rd_ready;
   logic [AW-1:0] wr_addr, rd_addr, mem_addr;
   logic [DW-1:0] wr_data, rsp_data, mem_din, mem_dout;
   logic          rsp_valid, rsp_ready, mem_en, mem_we, busy;
   logic [31:0]   stat_conflict;

   always #5 clk = ~clk;

   uram_polyvec_arb #(
      .COE_WIDTH (CW), .ADDR_WIDTH (AW), .NUM_POLY (NP),
      .COMMON_URAM_DELAY (1), .RSP_DEPTH (DEPTH)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_addr (wr_addr), .wr_data (wr_data),
      .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_addr (rd_addr),
      .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_data (rsp_data),
      .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_din (mem_din),
      .mem_dout (mem_dout), .busy (busy), .stat_conflict (stat_conflict)
   );

   // URAM model: the array register followed by one output pipeline register.
   logic [DW-1:0] uram [0:(1<<AW)-1];
   logic [DW-1:0] uStage0, uStage1;
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) uram[mem_addr] <= mem_din;
         else        uStage0 <= uram[mem_addr];
      end
      uStage1 <= uStage0;
   end
   assign mem_dout = uStage1;

   typedef struct {
      logic [DW-1:0] data;
      int            rdy;
   } rsp_t;

   rsp_t          q[$];
   logic [DW-1:0] memModel [int];
   bit            mLastRead;
   int            mStat;
   int            cyc;
   int            checks, errors;
   int            rdGrants, rspCount;
   logic          sWr, sRd;

   task automatic compareBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d actual=%b required=%b", name, cyc, act, exp);
      end
   endtask

   task automatic compareVec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkData(input int a);
      logic [DW-1:0] d;
      d = '0;
      for (int p = 0; p < NP; p++) d[p*CW +: CW] = CW'(a + p);
      return d;
   endfunction

   function automatic logic [DW-1:0] randData();
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < 5; k++) d = {d[DW-33:0], 32'($urandom)};
      return d;
   endfunction

   // Compares every DUT output against the reference model for the current
   // inputs, then advances the model past the coming clock edge.
   task automatic checkOutput();
      bit eW, eR, conf, expRsp;
      int expStat;
      if (!rst_n) begin
         q.delete();
         mLastRead = 1'b1;
         mStat     = 0;
      end
      eW = 1'b0; eR = 1'b0; conf = 1'b0;
      if (rst_n) begin
         eW   = wr_valid;
         eR   = rd_valid && (q.size() < DEPTH);
         conf = eW && eR;
         if (conf) begin
            if (mLastRead) eR = 1'b0;
            else           eW = 1'b0;
         end
      end
      sWr = wr_ready;
      sRd = rd_ready;
      compareBit("wr_ready", wr_ready, eW);
      compareBit("rd_ready", rd_ready, eR);
      compareBit("mem_en", mem_en, eW || eR);
      compareBit("mem_we", mem_we, eW);
      if (eW || eR) compareVec("mem_addr", DW'(mem_addr), DW'(eW ? wr_addr : rd_addr));
      if (eW) compareVec("mem_din", mem_din, wr_data);
      expRsp = rst_n && (q.size() > 0) && (q[0].rdy <= cyc);
      compareBit("rsp_valid", rsp_valid, expRsp);
      if (expRsp) compareVec("rsp_data", rsp_data, q[0].data);
      compareBit("busy", busy, q.size() > 0);
`ifdef URAM_ARB_STAT_EN
      expStat = mStat;
`else
      expStat = 0;
`endif
      compareVec("stat_conflict", DW'(stat_conflict), DW'(expStat));
      if (rst_n) begin
         if (conf) begin
            mLastRead = eR;
            mStat++;
         end
         if (expRsp && rsp_ready) begin
            void'(q.pop_front());
            rspCount++;
         end
         if (eW) memModel[int'(wr_addr)] = wr_data;
         if (eR) begin
            q.push_back('{data: memModel[int'(rd_addr)], rdy: cyc + 3});
            rdGrants++;
         end
      end
   endtask

   // Drives one cycle of inputs just after a rising edge, checks at the
   // falling edge, and returns just after the next rising edge.
   task automatic applyStimulus(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                input bit rv, input logic [AW-1:0] ra, input bit rr);
      wr_valid  = wv;
      wr_addr   = wa;
      wr_data   = wd;
      rd_valid  = rv;
      rd_addr   = ra;
      rsp_ready = rr;
      @(negedge clk);
      checkOutput();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n, input bit rr);
      for (int i = 0; i < n; i++) applyStimulus(0, '0, '0, 0, '0, rr);
   endtask

   typedef struct {
      bit            wv;
      logic [AW-1:0] wa;
      bit            rv;
      logic [AW-1:0] ra;
      bit            expW;
      bit            expR;
   } vec_t;

   vec_t tbl[10];

   initial begin
      int g0, r0, expStat;
      logic [DW-1:0] bigVal;
      checks = 0; errors = 0; cyc = 0; rdGrants = 0; rspCount = 0;
      mLastRead = 1'b1; mStat = 0;

      // Both clients held high alternate W,R,... starting with the writer.
      for (int i = 0; i < 6; i++) begin
         tbl[i] = '{wv: 1, wa: AW'(100 + i), rv: 1, ra: AW'(i), expW: (i % 2 == 0), expR: (i % 2 == 1)};
      end
      tbl[6] = '{wv: 1, wa: AW'(106), rv: 0, ra: AW'(0), expW: 1, expR: 0};
      tbl[7] = '{wv: 0, wa: AW'(0),   rv: 1, ra: AW'(7), expW: 0, expR: 1};
      tbl[8] = '{wv: 0, wa: AW'(0),   rv: 0, ra: AW'(0), expW: 0, expR: 0};
      tbl[9] = '{wv: 1, wa: AW'(107), rv: 1, ra: AW'(3), expW: 1, expR: 0};

      rst_n = 1'b0;
      idle(3, 1);
      rst_n = 1'b1;
      idle(1, 1);

      // Fill addresses 0..15, then read 0..7 back in order.
      for (int a = 0; a < 16; a++) applyStimulus(1, AW'(a), mkData(a), 0, '0, 1);
      r0 = rspCount;
      for (int a = 0; a < 8; a++) applyStimulus(0, '0, '0, 1, AW'(a), 1);
      idle(6, 1);
      compareVec("seqRspCount", DW'(rspCount - r0), DW'(8));

      // Conflict table.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(tbl[i].wv, tbl[i].wa, mkData(100 + i), tbl[i].rv, tbl[i].ra, 1);
         compareBit("tblWr", sWr, tbl[i].expW);
         compareBit("tblRd", sRd, tbl[i].expR);
      end
`ifdef URAM_ARB_STAT_EN
      expStat = 7;
`else
      expStat = 0;
`endif
      compareVec("tblStat", DW'(stat_conflict), DW'(expStat));
      idle(6, 1);

      // Consumer stalled: only DEPTH reads may be granted.
      g0 = rdGrants;
      for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, 1, AW'(i), 0);
      compareVec("stallGrants", DW'(rdGrants - g0), DW'(DEPTH));
      compareBit("stallRdReady", sRd, 1'b0);
      g0 = rdGrants;
      for (int i = 0; i < 8; i++) applyStimulus(0, '0, '0, 1, AW'(i), 1);
      compareBit("resumeGrants", rdGrants > g0, 1'b1);
      idle(6, 1);

      // Write followed immediately by a read of the same address.
      bigVal = {NP{35'h1_2345_6789}};
      applyStimulus(1, AW'(5), bigVal, 0, '0, 1);
      applyStimulus(0, '0, '0, 1, AW'(5), 1);
      idle(2, 1);
      compareVec("rawData", rsp_data, bigVal);
      idle(3, 1);

      // Reset while reads are in flight.
      applyStimulus(0, '0, '0, 1, AW'(0), 1);
      applyStimulus(0, '0, '0, 1, AW'(1), 1);
      rst_n = 1'b0;
      idle(2, 1);
      rst_n = 1'b1;
      idle(5, 1);
      applyStimulus(1, AW'(9), mkData(9), 0, '0, 1);
      compareBit("postResetWrite", sWr, 1'b1);

      // Randomized traffic over the initialised address range.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 1), AW'($urandom_range(0, 15)), randData(),
                       $urandom_range(0, 1), AW'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
      end

      // Drain with a bounded wait.
      for (int i = 0; i < 30; i++) begin
         if (!busy) break;
         idle(1, 1);
      end
      compareBit("drainBusy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
